pc_sequencer: RTL and testbench

//   Parametrised program counter: next generation of the 5-bit increment/clear PC.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with jump, PC-relative branch and call/return via a LIFO
// return-address stack. Define PC_STACK_ERR_EN to add the sticky Err overflow/underflow flag.
module pc_sequencer #(
   parameter int unsigned   W         = 5,
   parameter int unsigned   DEPTH     = 4,
   parameter logic [W-1:0]  RESET_VEC = '0
) (
   input  logic                         Clock,
   input  logic                         Clear,
   input  logic                         Up,
   input  logic                         Jump,
   input  logic                         Branch,
   input  logic                         Call,
   input  logic                         Ret,
   input  logic [W-1:0]                 Target,
   input  logic [W-1:0]                 Offset,
   output logic [W-1:0]                 O,
   output logic [$clog2(DEPTH+1)-1:0]   Level,
   output logic                         StackFull,
   output logic                         StackEmpty
`ifdef PC_STACK_ERR_EN
   ,
   output logic                         Err
`endif
);

   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_UP,
      OP_BRANCH,
      OP_JUMP,
      OP_CALL,
      OP_RET
   } op_e;

   op_e            op;
   logic [W-1:0]   stack [DEPTH];
   logic [W-1:0]   next_o;
   logic [W-1:0]   o_inc;
   logic [LW-1:0]  next_level;
   logic [IW-1:0]  push_idx;
   logic [IW-1:0]  pop_idx;
   logic           push;

   assign StackFull  = (Level == LW'(DEPTH));
   assign StackEmpty = (Level == '0);
   assign o_inc      = O + W'(1);
   // Level < DEPTH whenever a push happens, so truncating to the RAM index is safe.
   assign push_idx   = IW'(Level);
   assign pop_idx    = IW'(Level - LW'(1));

   always_comb begin
      op = OP_HOLD;
      if (Ret)
         op = OP_RET;
      else if (Call)
         op = OP_CALL;
      else if (Jump)
         op = OP_JUMP;
      else if (Branch)
         op = OP_BRANCH;
      else if (Up)
         op = OP_UP;
   end

   always_comb begin
      next_o     = O;
      next_level = Level;
      push       = 1'b0;
      case (op)
         OP_UP:     next_o = o_inc;
         OP_BRANCH: next_o = O + Offset;
         OP_JUMP:   next_o = Target;
         OP_CALL: begin
            next_o = Target;
            if (!StackFull) begin
               push       = 1'b1;
               next_level = Level + LW'(1);
            end
         end
         OP_RET: begin
            if (!StackEmpty) begin
               next_o     = stack[pop_idx];
               next_level = Level - LW'(1);
            end else begin
               next_o = o_inc;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         O     <= RESET_VEC;
         Level <= '0;
      end else begin
         O     <= next_o;
         Level <= next_level;
      end
   end

   // Stack RAM carries no reset; only Level qualifies its contents.
   always_ff @(posedge Clock) begin
      if (!Clear && push)
         stack[push_idx] <= o_inc;
   end

`ifdef PC_STACK_ERR_EN
   logic err_set;

   assign err_set = ((op == OP_CALL) && StackFull) || ((op == OP_RET) && StackEmpty);

   always_ff @(posedge Clock) begin
      if (Clear)
         Err <= 1'b0;
      else if (err_set)
         Err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle scoreboard from a behavioural model
// plus directed constant checks; builds with or without PC_STACK_ERR_EN.
module tb_pc_sequencer;

   localparam int W     = 5;
   localparam int DEPTH = 4;
   localparam int MOD   = 1 << W;
   localparam int LW    = $clog2(DEPTH + 1);

   logic           Clock = 1'b0;
   logic           Clear = 1'b0, Up = 1'b0, Jump = 1'b0, Branch = 1'b0;
   logic           Call = 1'b0, Ret = 1'b0;
   logic [W-1:0]   Target = '0, Offset = '0;
   logic [W-1:0]   O;
   logic [LW-1:0]  Level;
   logic           StackFull, StackEmpty;
`ifdef PC_STACK_ERR_EN
   logic           Err;
`endif

   pc_sequencer #(.W(W), .DEPTH(DEPTH), .RESET_VEC(5'd0)) dut (
      .Clock      (Clock),
      .Clear      (Clear),
      .Up         (Up),
      .Jump       (Jump),
      .Branch     (Branch),
      .Call       (Call),
      .Ret        (Ret),
      .Target     (Target),
      .Offset     (Offset),
      .O          (O),
      .Level      (Level),
      .StackFull  (StackFull),
      .StackEmpty (StackEmpty)
`ifdef PC_STACK_ERR_EN
      ,
      .Err        (Err)
`endif
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int o;
      int lvl;
      bit full;
      bit empty;
      bit err;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int   m_o   = 0;
   int   m_lvl = 0;
   int   m_stk [DEPTH];
   bit   m_err = 1'b0;

   // Drive one cycle, advance the reference model, queue its prediction.
   task automatic cyc(input bit c, input bit u, input bit j, input bit b,
                      input bit ca, input bit r, input int tgt, input int off);
      exp_t e;
      Clear = c; Up = u; Jump = j; Branch = b; Call = ca; Ret = r;
      Target = W'(tgt); Offset = W'(off);
      if (c) begin
         m_o = 0; m_lvl = 0; m_err = 1'b0;
      end else if (r) begin
         if (m_lvl > 0) begin
            m_lvl = m_lvl - 1;
            m_o   = m_stk[m_lvl];
         end else begin
            m_o   = (m_o + 1) % MOD;
            m_err = 1'b1;
         end
      end else if (ca) begin
         if (m_lvl < DEPTH) begin
            m_stk[m_lvl] = (m_o + 1) % MOD;
            m_lvl        = m_lvl + 1;
         end else begin
            m_err = 1'b1;
         end
         m_o = tgt % MOD;
      end else if (j) begin
         m_o = tgt % MOD;
      end else if (b) begin
         m_o = (m_o + (off % MOD)) % MOD;
      end else if (u) begin
         m_o = (m_o + 1) % MOD;
      end
      e.o = m_o; e.lvl = m_lvl; e.full = (m_lvl == DEPTH); e.empty = (m_lvl == 0); e.err = m_err;
      q.push_back(e);
      @(posedge Clock);
      #1;
      Clear = 0; Up = 0; Jump = 0; Branch = 0; Call = 0; Ret = 0;
   endtask

   always @(negedge Clock) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         if (O !== W'(e.o) || Level !== LW'(e.lvl) || StackFull !== e.full ||
             StackEmpty !== e.empty) begin
            n_bad++;
            $display("FAIL sb_state t=%0t: O=%0d Level=%0d Full=%0b Empty=%0b, required O=%0d Level=%0d Full=%0b Empty=%0b",
                     $time, O, Level, StackFull, StackEmpty, e.o, e.lvl, e.full, e.empty);
         end
`ifdef PC_STACK_ERR_EN
         n_cmp++;
         if (Err !== e.err) begin
            n_bad++;
            $display("FAIL sb_err t=%0t: Err=%0b required %0b", $time, Err, e.err);
         end
`endif
      end
   end

   task automatic test_reset;
      cyc(1, 1, 1, 1, 1, 1, 9, 3);
      n_cmp++;
      if (O !== 5'd0 || Level !== 3'd0 || StackEmpty !== 1'b1 || StackFull !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: O=%0d Level=%0d Empty=%0b Full=%0b, required 0 0 1 0",
                  O, Level, StackEmpty, StackFull);
      end
   endtask

   task automatic test_up_wrap;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 33; i++) begin
         cyc(0, 1, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if (O !== W'(i % MOD) || Level !== 3'd0) begin
            n_bad++;
            $display("FAIL up_wrap step %0d: O=%0d Level=%0d, required O=%0d Level=0",
                     i, O, Level, i % MOD);
         end
      end
   endtask

   task automatic test_branch;
      cyc(0, 0, 1, 0, 0, 0, 10, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 5'b11101);
      n_cmp++;
      if (O !== 5'd7) begin
         n_bad++;
         $display("FAIL branch_back: O=%0d required 7", O);
      end
      cyc(0, 0, 1, 0, 0, 0, 30, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 4);
      n_cmp++;
      if (O !== 5'd2) begin
         n_bad++;
         $display("FAIL branch_wrap: O=%0d required 2", O);
      end
   endtask

   task automatic test_call_ret;
      cyc(0, 0, 1, 0, 0, 0, 3, 0);
      cyc(0, 0, 0, 0, 1, 0, 20, 0);
      n_cmp++;
      if (O !== 5'd20 || Level !== 3'd1) begin
         n_bad++;
         $display("FAIL call: O=%0d Level=%0d, required O=20 Level=1", O, Level);
      end
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      n_cmp++;
      if (O !== 5'd4 || Level !== 3'd0 || StackEmpty !== 1'b1) begin
         n_bad++;
         $display("FAIL ret: O=%0d Level=%0d Empty=%0b, required O=4 Level=0 Empty=1",
                  O, Level, StackEmpty);
      end
   endtask

   task automatic test_nested;
      int tg [5] = '{8, 12, 16, 20, 24};
      int rv [4] = '{17, 13, 9, 1};
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 1, 0, tg[i], 0);
         if (i == 3) begin
            n_cmp++;
            if (StackFull !== 1'b1 || Level !== 3'd4) begin
               n_bad++;
               $display("FAIL nest_full: Full=%0b Level=%0d, required 1 4", StackFull, Level);
            end
         end
      end
      n_cmp++;
      if (O !== 5'd24 || Level !== 3'd4) begin
         n_bad++;
         $display("FAIL nest_overflow: O=%0d Level=%0d, required O=24 Level=4", O, Level);
      end
`ifdef PC_STACK_ERR_EN
      n_cmp++;
      if (Err !== 1'b1) begin
         n_bad++;
         $display("FAIL nest_err: Err=%0b required 1", Err);
      end
`endif
      // Return addresses are each caller's PC + 1: callers sat at 0, 8, 12, 16.
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 0, 1, 0, 0);
         n_cmp++;
         if (O !== W'(rv[i]) || Level !== LW'(3 - i)) begin
            n_bad++;
            $display("FAIL nest_ret %0d: O=%0d Level=%0d, required O=%0d Level=%0d",
                     i, O, Level, rv[i], 3 - i);
         end
      end
   endtask

   task automatic test_underflow;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 6, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      n_cmp++;
      if (O !== 5'd7 || Level !== 3'd0) begin
         n_bad++;
         $display("FAIL underflow: O=%0d Level=%0d, required O=7 Level=0", O, Level);
      end
`ifdef PC_STACK_ERR_EN
      n_cmp++;
      if (Err !== 1'b1) begin
         n_bad++;
         $display("FAIL underflow_err: Err=%0b required 1", Err);
      end
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (Err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky: Err=%0b required 1", Err);
      end
`endif
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (O !== 5'd0) begin
         n_bad++;
         $display("FAIL underflow_clear: O=%0d required 0", O);
      end
`ifdef PC_STACK_ERR_EN
      n_cmp++;
      if (Err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: Err=%0b required 0", Err);
      end
`endif
   endtask

   task automatic test_priority;
      cyc(0, 0, 1, 0, 0, 0, 11, 0);
      cyc(1, 1, 0, 0, 1, 0, 20, 0);
      n_cmp++;
      if (O !== 5'd0 || Level !== 3'd0) begin
         n_bad++;
         $display("FAIL prio_clear: O=%0d Level=%0d, required 0 0", O, Level);
      end
      cyc(0, 0, 0, 0, 1, 0, 20, 0);
      cyc(0, 1, 1, 1, 1, 1, 5, 2);
      n_cmp++;
      if (O !== 5'd1 || Level !== 3'd0) begin
         n_bad++;
         $display("FAIL prio_ret_call: O=%0d Level=%0d, required O=1 Level=0", O, Level);
      end
      cyc(0, 1, 1, 1, 0, 0, 14, 3);
      n_cmp++;
      if (O !== 5'd14) begin
         n_bad++;
         $display("FAIL prio_jump: O=%0d required 14", O);
      end
      cyc(0, 1, 0, 1, 0, 0, 0, 3);
      n_cmp++;
      if (O !== 5'd17) begin
         n_bad++;
         $display("FAIL prio_branch: O=%0d required 17", O);
      end
      cyc(0, 0, 0, 0, 0, 0, 2, 2);
      n_cmp++;
      if (O !== 5'd17 || Level !== 3'd0) begin
         n_bad++;
         $display("FAIL hold: O=%0d Level=%0d, required O=17 Level=0", O, Level);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
      end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_branch();
      test_call_ret();
      test_nested();
      test_underflow();
      test_priority();
      test_back_to_back();
      @(negedge Clock);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: %0d entries left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
